// File: rtl/lcb_responder.sv
// lcb_responder
//   Device end of the RS485 poll link. Receives a 4-byte request
//   {addr, start_reg, count, xor}, validates it, turns the half-duplex
//   line around and replies with `count` register bytes plus their XOR.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   rx              RS485 receive line (asynchronous, synchronised here)
//   tx              RS485 transmit line, idle high
//   dirTX / dirRX   driver enable / receiver enable (active-low), always equal
//   rd_en, rd_addr  register read strobe and address, one strobe per byte
//   rd_data         register data, valid the clk after rd_en
//   busy            high from the first request start bit to the end of the reply tail
//   rq_ok / err     1-clk pulses: request accepted / addressed frame rejected
//
// Handshake: rd_en is a single-cycle request with no back-pressure; rd_data is
// captured exactly one clk later, unconditionally.
module lcb_responder #(
   parameter int         CLKS_PER_BIT = 16,
   parameter logic [7:0] DEV_ADDR     = 8'h05,
   parameter int         RESP_MAX     = 16,
   parameter int         TURN_BITS    = 2,
   parameter int         TIMEOUT_BITS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       tx,
   output logic       dirTX,
   output logic       dirRX,
   output logic       rd_en,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       busy,
   output logic       rq_ok,
   output logic       err
);

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] TURN_LAST = 16'(TURN_BITS * CLKS_PER_BIT - 1);
   localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
   localparam logic [7:0]  RMAX      = 8'(RESP_MAX);

   // S_RX_GAP is the idle time between request bytes, where the timeout runs.
   typedef enum logic [3:0] {
      S_IDLE, S_RX_BYTE, S_RX_GAP, S_CHECK, S_TURN,
      S_TX_FETCH, S_TX_SHIFT, S_TX_CSUM, S_TAIL
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;       // clk counter: bit timing, turnaround, timeout
   logic [3:0]  bit_q, bit_d;       // 0 = start, 1..8 data, 9 = stop
   logic [1:0]  byte_q, byte_d;     // request byte index
   logic [7:0]  rsh_q, rsh_d;       // receive shift register
   logic [7:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
   logic [7:0]  idx_q, idx_d;       // reply data byte index
   logic [7:0]  csum_q, csum_d;     // running XOR of sent data bytes
   logic [9:0]  tsh_q, tsh_d;       // {stop, data, start}, shifted out LSB first
   logic        rx_m_q, rx_s_q, rx_p_q;
   logic        rx_fall;

   assign rx_fall = rx_p_q & ~rx_s_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         rsh_q   <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
         b2_q    <= '0;
         b3_q    <= '0;
         idx_q   <= '0;
         csum_q  <= '0;
         tsh_q   <= '1;
         rx_m_q  <= 1'b1;
         rx_s_q  <= 1'b1;
         rx_p_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         rsh_q   <= rsh_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         b2_q    <= b2_d;
         b3_q    <= b3_d;
         idx_q   <= idx_d;
         csum_q  <= csum_d;
         tsh_q   <= tsh_d;
         rx_m_q  <= rx;
         rx_s_q  <= rx_m_q;
         rx_p_q  <= rx_s_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      rsh_d   = rsh_q;
      b0_d    = b0_q;
      b1_d    = b1_q;
      b2_d    = b2_q;
      b3_d    = b3_q;
      idx_d   = idx_q;
      csum_d  = csum_q;
      tsh_d   = tsh_q;
      rd_en   = 1'b0;
      rq_ok   = 1'b0;
      err     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rx_fall) begin
               state_d = S_RX_BYTE;
               cnt_d   = '0;
               bit_d   = '0;
               byte_d  = '0;
            end
         end

         S_RX_GAP: begin
            cnt_d = cnt_q + 16'd1;
            if (rx_fall) begin
               state_d = S_RX_BYTE;
               cnt_d   = '0;
               bit_d   = '0;
            end else if (cnt_q == TOUT_LAST) begin
               state_d = S_IDLE;
            end
         end

         S_RX_BYTE: begin
            cnt_d = cnt_q + 16'd1;
            if (bit_q == 4'd0) begin
               if (cnt_q == HALF_LAST) begin
                  cnt_d = '0;
                  // Line back high mid start bit: a glitch, not a byte.
                  if (rx_s_q) state_d = (byte_q == 2'd0) ? S_IDLE : S_RX_GAP;
                  else        bit_d   = 4'd1;
               end
            end else if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               bit_d = bit_q + 4'd1;
               if (bit_q != 4'd9) begin
                  rsh_d = {rx_s_q, rsh_q[7:1]};
               end else if (!rx_s_q) begin
                  // Framing error: only report it when the frame was ours.
                  state_d = S_IDLE;
                  err     = (byte_q != 2'd0) && (b0_q == DEV_ADDR);
               end else begin
                  case (byte_q)
                     2'd0:    b0_d = rsh_q;
                     2'd1:    b1_d = rsh_q;
                     2'd2:    b2_d = rsh_q;
                     default: b3_d = rsh_q;
                  endcase
                  byte_d  = byte_q + 2'd1;
                  state_d = (byte_q == 2'd3) ? S_CHECK : S_RX_GAP;
               end
            end
         end

         S_CHECK: begin
            cnt_d = '0;
            if (b0_q != DEV_ADDR) begin
               state_d = S_IDLE;
            end else if (((b0_q ^ b1_q ^ b2_q) != b3_q) || (b2_q == 8'd0) || (b2_q > RMAX)) begin
               err     = 1'b1;
               state_d = S_IDLE;
            end else begin
               rq_ok   = 1'b1;
               idx_d   = '0;
               csum_d  = '0;
               state_d = S_TURN;
            end
         end

         S_TURN: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == TURN_LAST) begin
               cnt_d   = '0;
               state_d = S_TX_FETCH;
            end
         end

         // Cycle 0 strobes the read, cycle 1 captures the returned byte.
         S_TX_FETCH: begin
            if (cnt_q == 16'd0) begin
               rd_en = 1'b1;
               cnt_d = 16'd1;
            end else begin
               tsh_d   = {1'b1, rd_data, 1'b0};
               csum_d  = csum_q ^ rd_data;
               idx_d   = idx_q + 8'd1;
               cnt_d   = '0;
               bit_d   = '0;
               state_d = S_TX_SHIFT;
            end
         end

         S_TX_SHIFT, S_TX_CSUM: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               tsh_d = {1'b1, tsh_q[9:1]};
               bit_d = bit_q + 4'd1;
               if (bit_q == 4'd9) begin
                  bit_d = '0;
                  if (state_q == S_TX_CSUM) begin
                     state_d = S_TAIL;
                  end else if (idx_q == b2_q) begin
                     tsh_d   = {1'b1, csum_q, 1'b0};
                     state_d = S_TX_CSUM;
                  end else begin
                     state_d = S_TX_FETCH;
                  end
               end
            end
         end

         S_TAIL: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded straight from registers so reset clears them at once.
   assign tx      = ((state_q == S_TX_SHIFT) || (state_q == S_TX_CSUM)) ? tsh_q[0] : 1'b1;
   assign dirTX   = (state_q == S_TURN) || (state_q == S_TX_FETCH) || (state_q == S_TX_SHIFT) ||
                    (state_q == S_TX_CSUM) || (state_q == S_TAIL);
   assign dirRX   = dirTX;
   assign busy    = (state_q != S_IDLE);
   assign rd_addr = b1_q + idx_q;

endmodule

// File: tb/tb_lcb_responder.sv
// tb_lcb_responder
//   Drives request frames on rx, decodes the reply on tx, and compares
//   pulses, reply bytes, read addresses and driver window against a
//   frame-level reference model.
module tb_lcb_responder;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       tx;
   logic       dirTX;
   logic       dirRX;
   logic       rd_en;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       busy;
   logic       rq_ok;
   logic       err;

   logic [7:0] mem [256];
   int         n_checks  = 0;
   int         n_errors  = 0;
   int         rq_cnt    = 0;
   int         err_cnt   = 0;
   int         dir_cyc   = 0;
   int         both_cnt  = 0;
   int         dirrx_bad = 0;
   int         tx_bad    = 0;
   logic [7:0] got_q [$];
   logic [7:0] addr_q [$];
   logic [7:0] mon_b;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   lcb_responder dut (
      .clk     (clk),
      .rst     (rst),
      .rx      (rx),
      .tx      (tx),
      .dirTX   (dirTX),
      .dirRX   (dirRX),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .busy    (busy),
      .rq_ok   (rq_ok),
      .err     (err)
   );

   // Register file: data returned the clk after the strobe.
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   // Pulse / window monitors, sampled mid-cycle.
   always @(negedge clk) begin
      if (rq_ok) rq_cnt++;
      if (err) err_cnt++;
      if (rq_ok && err) both_cnt++;
      if (dirTX) dir_cyc++;
      if (dirRX !== dirTX) dirrx_bad++;
      if (rd_en) addr_q.push_back(rd_addr);
   end

   // UART decoder on tx while the driver is enabled.
   initial begin : tx_mon
      forever begin
         @(negedge clk);
         if (dirTX && !tx) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               mon_b = {tx, mon_b[7:1]};
            end
            repeat (CPB) @(negedge clk);
            if (tx !== 1'b1) tx_bad++;
            got_q.push_back(mon_b);
         end
      end
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic send_byte(input logic [7:0] b, input logic stop_val);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_val;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic wait_idle();
      repeat (2) @(negedge clk);
      for (int c = 0; c < 8000 && busy; c++) @(negedge clk);
      check_eq("idle_reached", busy, 1'b0);
   endtask

   // Send one frame and compare the result with the frame-level model.
   task automatic run_frame(input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] f2,
                            input logic [7:0] f3, input bit toggle_rx);
      logic [7:0] exp_q [$];
      logic [7:0] exp_a [$];
      logic [7:0] cs;
      logic [7:0] a;
      int exp_ok, exp_err, exp_dir;
      int r0, e0, d0, g0, a0;
      exp_ok = 0; exp_err = 0; exp_dir = 0; cs = 8'h00;
      if (f0 == 8'h05) begin
         if (((f0 ^ f1 ^ f2) != f3) || (f2 == 8'd0) || (f2 > 8'd16)) begin
            exp_err = 1;
         end else begin
            exp_ok = 1;
            for (int i = 0; i < int'(f2); i++) begin
               a = f1 + 8'(i);
               exp_a.push_back(a);
               exp_q.push_back(mem[a]);
               cs = cs ^ mem[a];
            end
            exp_q.push_back(cs);
            exp_dir = (2 + 10 * (int'(f2) + 1) + 1) * CPB + 2 * int'(f2);
         end
      end
      r0 = rq_cnt; e0 = err_cnt; d0 = dir_cyc; g0 = got_q.size(); a0 = addr_q.size();
      send_byte(f0, 1'b1);
      send_byte(f1, 1'b1);
      send_byte(f2, 1'b1);
      send_byte(f3, 1'b1);
      if (toggle_rx) begin
         for (int c = 0; c < 8000 && (got_q.size() - g0) < exp_q.size(); c++) begin
            @(negedge clk);
            rx = 1'($urandom_range(0, 1));
         end
         rx = 1'b1;
      end
      wait_idle();
      check_eq("rq_ok_pulses", rq_cnt - r0, exp_ok);
      check_eq("err_pulses", err_cnt - e0, exp_err);
      check_eq("dir_window", dir_cyc - d0, exp_dir);
      check_eq("reply_len", got_q.size() - g0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (g0 + i < got_q.size()) check_eq("reply_byte", got_q[g0 + i], exp_q[i]);
      check_eq("rd_count", addr_q.size() - a0, exp_a.size());
      for (int i = 0; i < exp_a.size(); i++)
         if (a0 + i < addr_q.size()) check_eq("rd_addr", addr_q[a0 + i], exp_a[i]);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int r0, e0, g0;
      logic [7:0] f0, f1, f2, f3;
      rst = 1'b1;
      rx  = 1'b1;
      for (int k = 0; k < 256; k++) mem[k] = 8'(8'h40 + k);
      repeat (3) @(negedge clk);
      check_eq("rst_tx", tx, 1'b1);
      check_eq("rst_dirTX", dirTX, 1'b0);
      check_eq("rst_dirRX", dirRX, 1'b0);
      check_eq("rst_rd_en", rd_en, 1'b0);
      check_eq("rst_rd_addr", rd_addr, 8'h00);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_rq_ok", rq_ok, 1'b0);
      check_eq("rst_err", err, 1'b0);
      rst = 1'b0;
      repeat (4 * CPB) @(negedge clk);

      // Valid request, other address, bad checksum / count.
      run_frame(8'h05, 8'h10, 8'h03, 8'h16, 1'b0);
      run_frame(8'h06, 8'h10, 8'h03, 8'h15, 1'b0);
      run_frame(8'h05, 8'h10, 8'h03, 8'h17, 1'b0);
      run_frame(8'h05, 8'h00, 8'h00, 8'h05, 1'b0);
      run_frame(8'h05, 8'h00, 8'h11, 8'h14, 1'b0);

      // Partial frame abandoned by inter-byte timeout, then a wrapping read.
      r0 = rq_cnt; e0 = err_cnt;
      send_byte(8'h05, 1'b1);
      send_byte(8'h10, 1'b1);
      repeat (25 * CPB) @(negedge clk);
      check_eq("tout_busy", busy, 1'b0);
      check_eq("tout_rq_ok", rq_cnt - r0, 0);
      check_eq("tout_err", err_cnt - e0, 0);
      run_frame(8'h05, 8'hFE, 8'h03, 8'hF8, 1'b0);

      // Stop-bit error inside an addressed frame, then recovery.
      r0 = rq_cnt; e0 = err_cnt;
      send_byte(8'h05, 1'b1);
      send_byte(8'h10, 1'b0);
      repeat (3 * CPB) @(negedge clk);
      check_eq("frm_err", err_cnt - e0, 1);
      check_eq("frm_rq_ok", rq_cnt - r0, 0);
      check_eq("frm_busy", busy, 1'b0);
      run_frame(8'h05, 8'h10, 8'h03, 8'h16, 1'b0);

      // Reset during the second reply byte.
      g0 = got_q.size();
      send_byte(8'h05, 1'b1);
      send_byte(8'h10, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h16, 1'b1);
      for (int c = 0; c < 4000 && (got_q.size() - g0) < 1; c++) @(negedge clk);
      repeat (3 * CPB) @(negedge clk);
      check_eq("pre_rst_dirTX", dirTX, 1'b1);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_tx", tx, 1'b1);
      check_eq("arst_dirTX", dirTX, 1'b0);
      check_eq("arst_busy", busy, 1'b0);
      check_eq("arst_rd_en", rd_en, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (15 * CPB) @(negedge clk);
      run_frame(8'h05, 8'h10, 8'h03, 8'h16, 1'b1);

      // Randomized frames against the model.
      for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
      for (int t = 0; t < 10; t++) begin
         f0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h05;
         f1 = 8'($urandom);
         f2 = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 18)) : 8'($urandom_range(1, 4));
         f3 = f0 ^ f1 ^ f2;
         if ($urandom_range(0, 4) == 0) f3 = f3 ^ (8'h01 << $urandom_range(0, 7));
         run_frame(f0, f1, f2, f3, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(1, 3) * CPB) @(negedge clk);
      end

      check_eq("rq_err_overlap", both_cnt, 0);
      check_eq("dirRX_equal", dirrx_bad, 0);
      check_eq("tx_stop_bits", tx_bad, 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
